// File: rtl/mcdf_regs_pkg.sv
// -----------------------------------------------------------------------------
// mcdf_regs_pkg
// Shared definitions for the MCDF register block:
//   - cmd_e        : register-bus command encoding (2'b11 is decoded as idle)
//   - address map  : CTRL_BASE, STAT_BASE, ERR_ADDR, ADDR_STRIDE
//   - ctrl_reg_t   : CTRL word layout {len, prio, en} at default field widths
//   - field offsets and reset-value constants used by the channel slices
// Optional feature macro used by the block: MCDF_REGS_ERR_EN
// -----------------------------------------------------------------------------
package mcdf_regs_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE = 2'b00,
      CMD_RD   = 2'b01,
      CMD_WR   = 2'b10
   } cmd_e;

   localparam logic [31:0] CTRL_BASE   = 32'h0000_0000;
   localparam logic [31:0] STAT_BASE   = 32'h0000_0040;
   localparam logic [31:0] ERR_ADDR    = 32'h0000_0080;
   localparam logic [31:0] ADDR_STRIDE = 32'd4;

   // Up to 16 channels, so a 4-bit channel index covers every register bank.
   localparam int IDX_W = 4;

   localparam int DEF_PRIO_W = 2;
   localparam int DEF_LEN_W  = 3;

   typedef struct packed {
      logic [DEF_LEN_W-1:0]  len;
      logic [DEF_PRIO_W-1:0] prio;
      logic                  en;
   } ctrl_reg_t;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_PRIO_LSB = 1;

   // The len field sits directly above the prio field, whatever its width.
   function automatic int ctrlLenLsb(input int prioW);
      return prioW + 1;
   endfunction

   localparam logic RST_EN      = 1'b1;
   localparam logic RST_PENDING = 1'b0;

   localparam ctrl_reg_t CTRL_RST = '{len: '0, prio: '1, en: RST_EN};

endpackage

// File: rtl/mcdf_regs_ch_slice.sv
// -----------------------------------------------------------------------------
// mcdf_regs_ch_slice
// Per-channel CTRL storage: shadow word (what software last wrote and reads
// back), active word (what drives the channel) and a pending flag. Pending
// shadow values are promoted to active only while the channel is idle between
// packets; a write that clears the enable bit takes effect immediately.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   i_wrEn      write strobe for this channel's CTRL register
//   i_wrData    CTRL word being written
//   i_idle      channel is between packets (commit allowed)
//   o_shadow    shadow word, used for CTRL read-back
//   o_en        active enable
//   o_prio      active priority
//   o_len       active packet-length code
// -----------------------------------------------------------------------------
module mcdf_regs_ch_slice
   import mcdf_regs_pkg::*;
#(
   parameter int PRIO_W = 2,
   parameter int LEN_W  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_wrEn,
   input  logic [PRIO_W+LEN_W:0]     i_wrData,
   input  logic                      i_idle,
   output logic [PRIO_W+LEN_W:0]     o_shadow,
   output logic                      o_en,
   output logic [PRIO_W-1:0]         o_prio,
   output logic [LEN_W-1:0]          o_len
);

   localparam int CTRL_W  = 1 + PRIO_W + LEN_W;
   localparam int LEN_LSB = ctrlLenLsb(PRIO_W);
   localparam logic [CTRL_W-1:0] RST_WORD = {{LEN_W{1'b0}}, {PRIO_W{1'b1}}, RST_EN};

   logic [CTRL_W-1:0] r_shadow;
   logic [CTRL_W-1:0] r_active;
   logic              r_pending;

   // A write always lands in the shadow. Disabling writes go straight through
   // to the active word so a channel can be stopped mid-packet; any other
   // write waits for the channel to go idle. A write in the same cycle as an
   // idle commit wins, so the newest value is what eventually gets committed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow  <= RST_WORD;
         r_active  <= RST_WORD;
         r_pending <= RST_PENDING;
      end else if (i_wrEn) begin
         r_shadow <= i_wrData;
         if (!i_wrData[CTRL_EN_BIT]) begin
            r_active  <= i_wrData;
            r_pending <= 1'b0;
         end else begin
            r_pending <= 1'b1;
         end
      end else if (r_pending && i_idle) begin
         r_active  <= r_shadow;
         r_pending <= 1'b0;
      end
   end

   assign o_shadow = r_shadow;
   assign o_en     = r_active[CTRL_EN_BIT];
   assign o_prio   = r_active[CTRL_PRIO_LSB +: PRIO_W];
   assign o_len    = r_active[LEN_LSB +: LEN_W];

endmodule

// File: rtl/mcdf_regs_multi_ch.sv
// -----------------------------------------------------------------------------
// mcdf_regs_multi_ch
// MCDF control/status register block for CH_NUM slave channels. Decodes the
// cmd/addr/data register bus into per-channel CTRL slices, returns FIFO
// availability through STAT registers and provides a registered read port.
// Optional error register and interrupt enabled by defining MCDF_REGS_ERR_EN.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_cmd           00 idle, 01 read, 10 write, 11 idle
//   i_cmd_addr      register byte address
//   i_cmd_data_w    write data
//   o_cmd_data_r    read data, one cycle after the read command, held
//   i_ch_avail      per-channel free FIFO slots, AVAIL_W bits each
//   i_ch_idle       per-channel packet-boundary flag
//   o_ch_en         active enable per channel
//   o_ch_prio       active priority per channel (0 = highest)
//   o_ch_len        active packet-length code per channel
//   o_err_irq       sticky error interrupt (MCDF_REGS_ERR_EN builds only)
// -----------------------------------------------------------------------------
module mcdf_regs_multi_ch
   import mcdf_regs_pkg::*;
#(
   parameter int CH_NUM     = 3,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 32,
   parameter int PRIO_W     = 2,
   parameter int LEN_W      = 3,
   localparam int AVAIL_W   = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  i_cmd,
   input  logic [ADDR_W-1:0]           i_cmd_addr,
   input  logic [DATA_W-1:0]           i_cmd_data_w,
   output logic [DATA_W-1:0]           o_cmd_data_r,
   input  logic [CH_NUM*AVAIL_W-1:0]   i_ch_avail,
   input  logic [CH_NUM-1:0]           i_ch_idle,
   output logic [CH_NUM-1:0]           o_ch_en,
   output logic [CH_NUM*PRIO_W-1:0]    o_ch_prio,
   output logic [CH_NUM*LEN_W-1:0]     o_ch_len
`ifdef MCDF_REGS_ERR_EN
   ,
   output logic                        o_err_irq
`endif
);

   localparam int CTRL_W = 1 + PRIO_W + LEN_W;
   localparam logic [31:0] BANK_SPAN = ADDR_STRIDE * 32'(CH_NUM);

   logic              w_isRd;
   logic              w_isWr;
   logic [31:0]       w_addr32;
   logic [31:0]       w_ctrlOff;
   logic [31:0]       w_statOff;
   logic              w_ctrlHit;
   logic              w_statHit;
   logic [IDX_W-1:0]  w_ctrlIdx;
   logic [IDX_W-1:0]  w_statIdx;
   logic [CH_NUM-1:0] w_wrSel;
   logic [CTRL_W-1:0] w_shadow [CH_NUM];
   logic [DATA_W-1:0] w_rdData;
   logic [DATA_W-1:0] r_cmdDataR;
   logic              w_unusedBits;

   assign w_isRd = (i_cmd == CMD_RD);
   assign w_isWr = (i_cmd == CMD_WR);

   // Offsets are taken relative to each bank base; an address below the base
   // wraps to a huge value and simply fails the span check.
   assign w_addr32  = 32'(i_cmd_addr);
   assign w_ctrlOff = w_addr32 - CTRL_BASE;
   assign w_statOff = w_addr32 - STAT_BASE;
   assign w_ctrlHit = (w_ctrlOff < BANK_SPAN) && (w_ctrlOff[1:0] == 2'b00);
   assign w_statHit = (w_statOff < BANK_SPAN) && (w_statOff[1:0] == 2'b00);
   assign w_ctrlIdx = w_ctrlOff[IDX_W+1:2];
   assign w_statIdx = w_statOff[IDX_W+1:2];

   // Only the CTRL field bits (and the ERR clear bits) of the write word matter.
   assign w_unusedBits = ^i_cmd_data_w;

   for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      assign w_wrSel[gi] = w_isWr && w_ctrlHit && (w_ctrlIdx == IDX_W'(gi));

      mcdf_regs_ch_slice #(
         .PRIO_W (PRIO_W),
         .LEN_W  (LEN_W)
      ) u_slice (
         .clk      (clk),
         .rst      (rst),
         .i_wrEn   (w_wrSel[gi]),
         .i_wrData (i_cmd_data_w[CTRL_W-1:0]),
         .i_idle   (i_ch_idle[gi]),
         .o_shadow (w_shadow[gi]),
         .o_en     (o_ch_en[gi]),
         .o_prio   (o_ch_prio[gi*PRIO_W +: PRIO_W]),
         .o_len    (o_ch_len[gi*LEN_W +: LEN_W])
      );
   end

`ifdef MCDF_REGS_ERR_EN
   logic       w_errHit;
   logic       w_unmapped;
   logic [1:0] w_errNext;
   logic [1:0] r_err;
   logic       r_errIrq;

   assign w_errHit   = (w_addr32 == ERR_ADDR);
   assign w_unmapped = (w_isRd || w_isWr) && !(w_ctrlHit || w_statHit || w_errHit);

   // Error flags are sticky and cleared by writing 1s to ERR. Setting is
   // applied after clearing so a new error in the clearing cycle is kept.
   always_comb begin
      w_errNext = r_err;
      if (w_isWr && w_errHit) begin
         w_errNext = r_err & ~i_cmd_data_w[1:0];
      end
      if (w_unmapped) begin
         w_errNext[0] = 1'b1;
      end
      if (w_isWr && w_statHit) begin
         w_errNext[1] = 1'b1;
      end
   end

   // The interrupt is registered from the next flag value so it tracks the
   // ERR register cycle for cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err    <= 2'b00;
         r_errIrq <= 1'b0;
      end else begin
         r_err    <= w_errNext;
         r_errIrq <= |w_errNext;
      end
   end

   assign o_err_irq = r_errIrq;
`endif

   // Read mux: CTRL returns the shadow word so software sees its own write
   // immediately, STAT samples the live FIFO level, everything else reads 0.
   always_comb begin
      w_rdData = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (w_ctrlHit && (w_ctrlIdx == IDX_W'(i))) begin
            w_rdData = DATA_W'(w_shadow[i]);
         end
         if (w_statHit && (w_statIdx == IDX_W'(i))) begin
            w_rdData = DATA_W'(i_ch_avail[i*AVAIL_W +: AVAIL_W]);
         end
      end
`ifdef MCDF_REGS_ERR_EN
      if (w_errHit) begin
         w_rdData = DATA_W'(r_err);
      end
`endif
   end

   // Read data is captured only on read cycles and held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmdDataR <= '0;
      end else if (w_isRd) begin
         r_cmdDataR <= w_rdData;
      end
   end

   assign o_cmd_data_r = r_cmdDataR;

endmodule

// File: tb/tb_mcdf_regs_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_mcdf_regs_multi_ch
// Directed bench for mcdf_regs_multi_ch (CH_NUM=3, default widths). Read
// expectations are queued when a read is issued and compared by a separate
// monitor when the read data becomes valid; channel outputs are compared
// directly. Build with MCDF_REGS_ERR_EN defined to also exercise ERR/err_irq.
// -----------------------------------------------------------------------------
module tb_mcdf_regs_multi_ch;
   import mcdf_regs_pkg::*;

   localparam int CH_NUM  = 3;
   localparam int AVAIL_W = 6;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [1:0]                 cmd;
   logic [7:0]                 cmdAddr;
   logic [31:0]                cmdDataW;
   logic [31:0]                cmdDataR;
   logic [CH_NUM*AVAIL_W-1:0]  chAvail;
   logic [CH_NUM-1:0]          chIdle;
   logic [CH_NUM-1:0]          chEn;
   logic [CH_NUM*2-1:0]        chPrio;
   logic [CH_NUM*3-1:0]        chLen;
`ifdef MCDF_REGS_ERR_EN
   logic                       errIrq;
`endif

   int vecCount  = 0;
   int missCount = 0;

   logic [31:0] expQ[$];
   string       nameQ[$];
   logic        rdValid;

   mcdf_regs_multi_ch #(
      .CH_NUM     (CH_NUM),
      .ADDR_W     (8),
      .DATA_W     (32),
      .FIFO_DEPTH (32),
      .PRIO_W     (2),
      .LEN_W      (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_cmd        (cmd),
      .i_cmd_addr   (cmdAddr),
      .i_cmd_data_w (cmdDataW),
      .o_cmd_data_r (cmdDataR),
      .i_ch_avail   (chAvail),
      .i_ch_idle    (chIdle),
      .o_ch_en      (chEn),
      .o_ch_prio    (chPrio),
      .o_ch_len     (chLen)
`ifdef MCDF_REGS_ERR_EN
      ,
      .o_err_irq    (errIrq)
`endif
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // A read issued in one cycle presents its data after the following edge.
   always @(posedge clk or posedge rst) begin
      if (rst) rdValid <= 1'b0;
      else     rdValid <= (cmd == 2'b01);
   end

   // Scoreboard monitor: pops one expectation per valid read result.
   always @(negedge clk) begin
      if (rdValid) begin
         vecCount++;
         if (expQ.size() == 0) begin
            missCount++;
            $display("[TB] FAIL unexpected_read: got 0x%08h, no expectation queued", cmdDataR);
         end else begin
            logic [31:0] e;
            string       n;
            e = expQ.pop_front();
            n = nameQ.pop_front();
            if (cmdDataR !== e) begin
               missCount++;
               $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", n, cmdDataR, e);
            end
         end
      end
   end

   function automatic logic [31:0] ctrlWord(input logic [2:0] len, input logic [1:0] prio,
                                            input logic en);
      ctrl_reg_t c;
      c.len  = len;
      c.prio = prio;
      c.en   = en;
      return 32'(c);
   endfunction

   // Drive one bus cycle at the falling edge; reads queue their expected data.
   task automatic applyStimulus(input string name, input logic [1:0] c, input logic [7:0] a,
                                input logic [31:0] d, input logic [31:0] expRd);
      if (c == 2'b01) begin
         expQ.push_back(expRd);
         nameQ.push_back(name);
      end
      cmd      = c;
      cmdAddr  = a;
      cmdDataW = d;
      @(negedge clk);
      cmd      = 2'b00;
      cmdAddr  = 8'h00;
      cmdDataW = 32'h0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rstWord;
      rstWord  = ctrlWord(3'd0, 2'd3, 1'b1);
      rst      = 1'b1;
      cmd      = 2'b00;
      cmdAddr  = 8'h00;
      cmdDataW = 32'h0;
      chIdle   = 3'b111;
      chAvail  = {6'd5, 6'd9, 6'd3};
      idleCycles(2);

      // Reset state
      checkOutput("rst_en",    32'(chEn),     32'h7);
      checkOutput("rst_prio",  32'(chPrio),   32'h3F);
      checkOutput("rst_len",   32'(chLen),    32'h0);
      checkOutput("rst_rdata", cmdDataR,      32'h0);
`ifdef MCDF_REGS_ERR_EN
      checkOutput("rst_irq",   32'(errIrq),   32'h0);
`endif
      rst = 1'b0;
      idleCycles(1);

      // 1: reset CTRL read-back
      applyStimulus("rd_ctrl0_rst", 2'b01, 8'h00, 32'h0, rstWord);
      applyStimulus("rd_ctrl1_rst", 2'b01, 8'h04, 32'h0, rstWord);
      applyStimulus("rd_ctrl2_rst", 2'b01, 8'h08, 32'h0, rstWord);

      // 2: shadowed write waits for idle
      chIdle = 3'b101;
      applyStimulus("wr_ctrl1", 2'b10, 8'h04, 32'h2B, 32'h0);
      checkOutput("ch1_prio_held", 32'(chPrio[3:2]), 32'd3);
      checkOutput("ch1_len_held",  32'(chLen[5:3]),  32'd0);
      applyStimulus("rd_ctrl1_shadow", 2'b01, 8'h04, 32'h0, ctrlWord(3'd5, 2'd1, 1'b1));
      checkOutput("ch1_len_still_held", 32'(chLen[5:3]), 32'd0);
      chIdle = 3'b111;
      idleCycles(1);
      checkOutput("ch1_prio_commit", 32'(chPrio[3:2]), 32'd1);
      checkOutput("ch1_len_commit",  32'(chLen[5:3]),  32'd5);

      // 3: disable bypasses idle
      chIdle = 3'b110;
      applyStimulus("wr_ctrl0_dis", 2'b10, 8'h00, 32'h0, 32'h0);
      checkOutput("ch0_disabled", 32'(chEn), 32'h6);
      applyStimulus("rd_ctrl0_dis", 2'b01, 8'h00, 32'h0, 32'h0);
      chIdle = 3'b111;

      // 4: STAT read latency and hold; STAT write ignored
      chAvail = {6'd17, 6'd9, 6'd3};
      applyStimulus("rd_stat2", 2'b01, 8'h48, 32'h0, 32'h11);
      for (int k = 0; k < 3; k++) begin
         checkOutput("stat2_hold", cmdDataR, 32'h11);
         idleCycles(1);
      end
      applyStimulus("wr_stat0", 2'b10, 8'h40, 32'hFF, 32'h0);
      applyStimulus("rd_stat0", 2'b01, 8'h40, 32'h0, 32'h3);
`ifdef MCDF_REGS_ERR_EN
      checkOutput("irq_after_stat_wr", 32'(errIrq), 32'h1);
`endif

      // 5: unmapped accesses
      applyStimulus("rd_ctrl3_unmapped", 2'b01, 8'h0C, 32'h0, 32'h0);
      applyStimulus("wr_ctrl3_unmapped", 2'b10, 8'h0C, 32'h0, 32'h0);
      checkOutput("en_after_unmapped_wr", 32'(chEn), 32'h6);
      applyStimulus("rd_stat3_unmapped", 2'b01, 8'h4C, 32'h0, 32'h0);
      applyStimulus("rd_misaligned",     2'b01, 8'h41, 32'h0, 32'h0);
      applyStimulus("wr_ctrl1_cmd11",    2'b11, 8'h04, 32'h0, 32'h0);
      checkOutput("cmd11_ignored", 32'(chEn), 32'h6);
`ifdef MCDF_REGS_ERR_EN
      applyStimulus("rd_err_set", 2'b01, 8'h80, 32'h0, 32'h3);
      checkOutput("irq_set", 32'(errIrq), 32'h1);
      applyStimulus("wr_err_clr", 2'b10, 8'h80, 32'h3, 32'h0);
      checkOutput("irq_clr", 32'(errIrq), 32'h0);
      applyStimulus("rd_err_clr", 2'b01, 8'h80, 32'h0, 32'h0);
`else
      applyStimulus("wr_err_noeffect", 2'b10, 8'h80, 32'h3, 32'h0);
      applyStimulus("rd_err_unmapped", 2'b01, 8'h80, 32'h0, 32'h0);
`endif

      // 6: reset discards a pending write
      chIdle = 3'b011;
      applyStimulus("wr_ctrl2_pending", 2'b10, 8'h08, 32'h2B, 32'h0);
      checkOutput("ch2_prio_pending", 32'(chPrio[5:4]), 32'd3);
      rst = 1'b1;
      idleCycles(1);
      checkOutput("rst2_en",    32'(chEn),   32'h7);
      checkOutput("rst2_prio",  32'(chPrio), 32'h3F);
      checkOutput("rst2_len",   32'(chLen),  32'h0);
      checkOutput("rst2_rdata", cmdDataR,    32'h0);
      chIdle = 3'b111;
      rst    = 1'b0;
      idleCycles(2);
      checkOutput("ch2_len_no_commit",  32'(chLen[8:6]),  32'd0);
      checkOutput("ch2_prio_no_commit", 32'(chPrio[5:4]), 32'd3);
      applyStimulus("rd_ctrl2_after_rst", 2'b01, 8'h08, 32'h0, rstWord);

      idleCycles(2);
      if (expQ.size() != 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL read_drain: got %0d outstanding, expected 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
